// File: rtl/video_stream_monitor.sv
// Receive-side checker/capture for the vsync/hsync/data stream: tags pixels with x/y, sums each frame
// and reports geometry status once per frame. Define VIDEO_STREAM_MONITOR_HTOTAL_CHECK_EN for the line-period check (vm_err[3]).
module video_stream_monitor #(
    parameter int DW      = 8,
    parameter int IW      = 4,
    parameter int IH      = 4,
    parameter int H_TOTAL = 10,
    parameter int XW      = 8,
    parameter int YW      = 8,
    parameter int SUM_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vm_din_vsync,
    input  logic             vm_din_hsync,
    input  logic [DW-1:0]    vm_din,
    output logic             vm_pix_valid,
    output logic [DW-1:0]    vm_pix_data,
    output logic [XW-1:0]    vm_pix_x,
    output logic [YW-1:0]    vm_pix_y,
    output logic             vm_frame_done,
    output logic             vm_frame_ok,
    output logic [YW-1:0]    vm_line_cnt,
    output logic [SUM_W-1:0] vm_frame_sum,
    output logic [15:0]      vm_frame_cnt,
`ifdef VIDEO_STREAM_MONITOR_HTOTAL_CHECK_EN
    output logic [3:0]       vm_err
`else
    output logic [2:0]       vm_err
`endif
);

`ifdef VIDEO_STREAM_MONITOR_HTOTAL_CHECK_EN
    localparam int EW = 4;
`else
    localparam int EW = 3;
    logic [31:0] unused_h_total;
    assign unused_h_total = 32'(H_TOTAL);
`endif

    typedef enum logic [1:0] {IDLE, FRAME, DONE} state_t;

    state_t           state_q, state_d;
    logic             vs_q, hs_q;
    logic [XW-1:0]    col_q, col_d;
    logic [YW-1:0]    line_q, line_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [EW-1:0]    werr_q, werr_d;
    logic             stray_q, stray_d;
    logic [XW-1:0]    pix_x_d;
    logic [YW-1:0]    pix_y_d;

    logic             pix_vld_q;
    logic [DW-1:0]    pix_dat_q;
    logic [XW-1:0]    pix_x_q;
    logic [YW-1:0]    pix_y_q;
    logic             done_q, ok_q;
    logic [YW-1:0]    line_cnt_q;
    logic [SUM_W-1:0] frame_sum_q;
    logic [15:0]      frame_cnt_q;
    logic [EW-1:0]    err_q;

    logic vs_rise, vs_fall, hs_fall, stray_hs;
    logic entering, in_frame, pix_take, close_line, done_now;

    assign vs_rise  = vm_din_vsync & ~vs_q;
    assign vs_fall  = ~vm_din_vsync & vs_q;
    assign hs_fall  = ~vm_din_hsync & hs_q;
    assign stray_hs = vm_din_hsync & ~vm_din_vsync;

    // DONE also accepts a new frame start so a back-to-back vsync rise is not lost
    assign entering   = (state_q != FRAME) && vs_rise;
    assign in_frame   = entering || (state_q == FRAME);
    assign pix_take   = in_frame && vm_din_vsync && vm_din_hsync;
    assign done_now   = (state_q == FRAME) && vs_fall;
    assign close_line = (state_q == FRAME) &&
                        (vm_din_vsync ? hs_fall : (vs_fall && hs_q));

`ifdef VIDEO_STREAM_MONITOR_HTOTAL_CHECK_EN
    logic [15:0] per_q, per_d;
    logic        seen_q, seen_d;
    logic        hs_rise;
    assign hs_rise = vm_din_hsync & ~hs_q & vm_din_vsync;
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        sum_d   = sum_q;
        werr_d  = werr_q;
        stray_d = stray_q;
`ifdef VIDEO_STREAM_MONITOR_HTOTAL_CHECK_EN
        per_d   = per_q;
        seen_d  = seen_q;
`endif

        if (entering) begin
            state_d   = FRAME;
            col_d     = '0;
            line_d    = '0;
            sum_d     = '0;
            werr_d    = '0;
            werr_d[2] = stray_q;
            stray_d   = 1'b0;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end

        // hsync without vsync outside a frame is reported with the next frame
        if (stray_hs) begin
            if (state_q == FRAME) werr_d[2] = 1'b1;
            else                  stray_d   = 1'b1;
        end

        pix_x_d = col_d;
        pix_y_d = line_d;
        if (pix_take) begin
            if (col_d != '1) col_d = col_d + XW'(1);
            sum_d = sum_d + SUM_W'(vm_din);
        end

`ifdef VIDEO_STREAM_MONITOR_HTOTAL_CHECK_EN
        if (entering) begin
            per_d  = '0;
            seen_d = 1'b0;
        end else if ((state_q == FRAME) && (per_q != '1)) begin
            per_d = per_q + 16'd1;
        end
        // per_q holds the clocks elapsed since the previous line start
        if (in_frame && hs_rise) begin
            if (seen_d && (per_q != 16'(H_TOTAL))) werr_d[3] = 1'b1;
            per_d  = 16'd1;
            seen_d = 1'b1;
        end
`endif

        if (close_line) begin
            if (col_d != XW'(IW)) werr_d[0] = 1'b1;
            if (line_d != '1)     line_d    = line_d + YW'(1);
            col_d = '0;
        end

        if (done_now) begin
            if (line_d != YW'(IH)) werr_d[1] = 1'b1;
            state_d = DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vs_q        <= 1'b1;  // a frame already in progress at release is ignored
            hs_q        <= 1'b0;
            col_q       <= '0;
            line_q      <= '0;
            sum_q       <= '0;
            werr_q      <= '0;
            stray_q     <= 1'b0;
            pix_vld_q   <= 1'b0;
            pix_dat_q   <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            line_cnt_q  <= '0;
            frame_sum_q <= '0;
            frame_cnt_q <= '0;
            err_q       <= '0;
`ifdef VIDEO_STREAM_MONITOR_HTOTAL_CHECK_EN
            per_q       <= '0;
            seen_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            vs_q      <= vm_din_vsync;
            hs_q      <= vm_din_hsync;
            col_q     <= col_d;
            line_q    <= line_d;
            sum_q     <= sum_d;
            werr_q    <= werr_d;
            stray_q   <= stray_d;
            pix_vld_q <= pix_take;
            done_q    <= done_now;
`ifdef VIDEO_STREAM_MONITOR_HTOTAL_CHECK_EN
            per_q     <= per_d;
            seen_q    <= seen_d;
`endif
            if (pix_take) begin
                pix_dat_q <= vm_din;
                pix_x_q   <= pix_x_d;
                pix_y_q   <= pix_y_d;
            end
            if (done_now) begin
                line_cnt_q  <= line_d;
                frame_sum_q <= sum_d;
                err_q       <= werr_d;
                ok_q        <= ~|werr_d;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign vm_pix_valid  = pix_vld_q;
    assign vm_pix_data   = pix_dat_q;
    assign vm_pix_x      = pix_x_q;
    assign vm_pix_y      = pix_y_q;
    assign vm_frame_done = done_q;
    assign vm_frame_ok   = ok_q;
    assign vm_line_cnt   = line_cnt_q;
    assign vm_frame_sum  = frame_sum_q;
    assign vm_frame_cnt  = frame_cnt_q;
    assign vm_err        = err_q;

endmodule

// File: doc/video_stream_monitor.md
Name: video_stream_monitor

Overview:
- Receive-side checker and capture for the vsync/hsync/data video stream used throughout the filter pipeline.
- Sits on any stage output, e.g. after the mean filter or another filter block.
- Tags each valid pixel with x/y coordinates and accumulates a per-frame pixel sum.
- Checks frame geometry against the configured image size and reports a status bundle once per frame.
- Synthesisable: usable on-chip for debug and as the checking end in benches.

Parameters:
- DW, 8, pixel data width
- IW, 4, expected active pixels per line
- IH, 4, expected lines per frame
- H_TOTAL, 10, expected clocks between consecutive hsync rising edges; used only with the optional feature
- XW, 8, width of the x coordinate and the column counter
- YW, 8, width of the y coordinate and the line counter
- SUM_W, 16, frame sum accumulator width

Ports:
- clk, in, 1, system clock
- rst, in, 1, asynchronous active-high reset
- vm_din_vsync, in, 1, frame valid
- vm_din_hsync, in, 1, line valid, qualifies vm_din
- vm_din, in, DW, pixel data
- vm_pix_valid, out, 1, registered copy of (vsync & hsync) while in frame
- vm_pix_data, out, DW, registered pixel
- vm_pix_x, out, XW, column of vm_pix_data
- vm_pix_y, out, YW, row of vm_pix_data
- vm_frame_done, out, 1, one-cycle pulse at end of frame
- vm_frame_ok, out, 1, no error flags set in last frame
- vm_line_cnt, out, YW, lines counted in last frame
- vm_frame_sum, out, SUM_W, pixel sum of last frame, modulo 2^SUM_W
- vm_frame_cnt, out, 16, completed frames since reset, wraps
- vm_err, out, 3, sticky per frame: [0] line length != IW, [1] line count != IH, [2] hsync high while vsync low

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset value: every output is 0 and the FSM is in IDLE.
- Edge detection: previous vsync and hsync are held in registers. Rise/fall is detected combinationally from the current input versus the registered previous value.
- IDLE:
  - wait for a vsync rising edge; go to FRAME.
  - vsync already high at reset release means that frame is ignored; the monitor waits for the next rising edge.
- FRAME, on entry: clear column counter, line counter, sum and the working error flags.
- FRAME, while vsync & hsync:
  - next cycle, vm_pix_valid=1, vm_pix_data=vm_din, vm_pix_x=column, vm_pix_y=line. Latency is 1 clock.
  - column increments, saturating at 2^XW-1.
  - sum += vm_din, wrapping.
- FRAME, on hsync falling edge (vsync high):
  - if column != IW, set err[0].
  - line increments, saturating; column clears.
- FRAME, vsync falling edge:
  - if hsync is still high, close the line first.
  - if final line count != IH, set err[1].
  - go to DONE.
- DONE, one cycle:
  - vm_frame_done=1.
  - vm_line_cnt, vm_frame_sum, vm_err and vm_frame_ok latch.
  - vm_frame_cnt increments.
  - go to IDLE.
  - status outputs hold until the next DONE.
  - timing: frame_done is high 1 clock after the first clock sampling vsync=0.
- Vsync rising edge in the same cycle as hsync high: first pixel is accepted at x=0.
- hsync=1 while vsync=0, any state: set err[2]. Outside FRAME the flag is carried into the next frame's report.
- vm_pix_valid is never asserted outside FRAME.
- Status outputs are not updated for an aborted frame (reset mid-frame).

Optional Feature:
- Macro: VIDEO_STREAM_MONITOR_HTOTAL_CHECK_EN.
- Enabled:
  - a period counter measures clocks between successive hsync rising edges within a frame.
  - any period != H_TOTAL sets a fourth flag, and vm_err widens to 4 bits with [3]=line period error.
  - the first line of a frame is not checked.
  - vm_frame_ok includes this flag.
- Disabled:
  - no period counter; vm_err is 3 bits; H_TOTAL is unused.

Test Plan:
- Nominal frame:
  - stimulus: vsync high, 8-clock gap, 4 lines of 4 pixels each (2,8,3,1 / 5,3,6,2 / 7,6,8,4 / 9,4,7,9), 6-clock line gaps, vsync low 2 clocks after the last line.
  - required response: one frame_done; frame_ok=1; line_cnt=4; frame_sum=84; err=0; frame_cnt=1.
  - last pixel (9) appears with x=3, y=3.
- Same frame sent twice with 50 idle clocks between:
  - required response: frame_cnt=2, frame_sum=84 both times, frame_done pulses exactly twice.
- Line 2 sent with only 3 pixels:
  - required response: err[0]=1, frame_ok=0, sum=82, line_cnt=4.
  - next clean frame reports err=0.
- Five lines sent:
  - required response: err[1]=1, line_cnt=5.
- Stray 1-clock hsync pulse with vsync low before a frame:
  - required response: that frame reports err[2]=1; vm_pix_valid stays 0 during the pulse.
- Reset mid-frame:
  - stimulus: rst asserted during line 2 with vsync still high.
  - required response: all outputs go to 0 immediately and no frame_done for that frame.
  - next full frame reports sum=84, frame_cnt=1.
  - with the macro defined, a 7-clock gap instead of 6 on line 3 sets err[3]=1.
